// File: rtl/tick_rate_pkg.sv
// Shared types and constants for the tick rate controller and its decade stages.
package tick_rate_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUN     = 2'd1,
        ST_STEP    = 2'd2
    } state_e;

    localparam logic [3:0] DECADE_MAX = 4'd9;

endpackage

// File: rtl/decade_stage.sv
// One divide-by-10 stage: counts 0..9 while enabled, flags its wrap as TC.
module decade_stage
    import tick_rate_pkg::*;
(
    input  logic       CLOCK,
    input  logic       CLEAR,
    input  logic       ZERO,
    input  logic       EN,
    output logic [3:0] COUNT,
    output logic       TC
);

    logic [3:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (ZERO) begin
            count_d = '0;
        end else if (EN) begin
            count_d = (count_q == DECADE_MAX) ? 4'd0 : count_q + 4'd1;
        end
    end

    always_ff @(negedge CLOCK or negedge CLEAR) begin
        if (!CLEAR) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign COUNT = count_q;
    assign TC    = EN && (count_q == DECADE_MAX);

endmodule

// File: rtl/tick_rate_controller.sv
// Run/stop/step controller: prescaler plus decade chain, with rate selection that
// only switches on a tick boundary so TICK never sees a glitched period.
module tick_rate_controller
    import tick_rate_pkg::*;
#(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned PW       = 16,
    parameter int unsigned STAGES   = 3,
    parameter int unsigned SW       = 2
) (
    input  logic                CLOCK,
    input  logic                CLEAR,
    input  logic                RUN,
    input  logic                STOP,
    input  logic                STEP,
    input  logic                ZERO,
    input  logic [SW-1:0]       SEL,
    output logic                TICK,
    output logic                SQUARE,
    output logic                RUNNING,
    output logic [SW-1:0]       ACT_SEL,
    output logic [4*STAGES-1:0] DIGITS
);

    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] SEL_MAX = SW'(STAGES);

    state_e            state_q, state_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic [SW-1:0]     act_sel_q, act_sel_d;
    logic              tick_q, tick_d;
    logic              square_q, square_d;

    logic              enabled;
    logic              pre_tc;
    logic              sel_tc;
    logic [SW-1:0]     sel_clamped;
    logic [STAGES-1:0] stage_en;
    logic [STAGES-1:0] stage_tc;
    logic [(1<<SW)-1:0] tc_vec;

    assign enabled = (state_q == ST_RUN);
    // ZERO masks the terminal so a clearing edge can never also produce a tick.
    assign pre_tc  = enabled && !ZERO && (pre_q == PRE_MAX);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign stage_en[k] = pre_tc;
        end else begin : g_rest
            assign stage_en[k] = stage_tc[k-1];
        end

        decade_stage u_stage (
            .CLOCK (CLOCK),
            .CLEAR (CLEAR),
            .ZERO  (ZERO),
            .EN    (stage_en[k]),
            .COUNT (DIGITS[4*k +: 4]),
            .TC    (stage_tc[k])
        );
    end

    always_comb begin
        tc_vec    = '0;
        tc_vec[0] = pre_tc;
        for (int k = 0; k < STAGES; k++) begin
            tc_vec[k+1] = stage_tc[k];
        end
    end

    assign sel_tc      = tc_vec[act_sel_q];
    assign sel_clamped = (SEL > SEL_MAX) ? SEL_MAX : SEL;

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        act_sel_d = act_sel_q;
        tick_d    = 1'b0;

        case (state_q)
            ST_STOPPED: begin
                if (STOP) begin
                    state_d = ST_STOPPED;
                end else if (RUN) begin
                    state_d = ST_RUN;
                end else if (STEP) begin
                    state_d = ST_STEP;
                end
                act_sel_d = sel_clamped;
            end
            ST_RUN: begin
                if (STOP) begin
                    state_d = ST_STOPPED;
                end
                tick_d = sel_tc;
                if (sel_tc) begin
                    act_sel_d = sel_clamped;
                end
            end
            ST_STEP: begin
                state_d = ST_STOPPED;
                tick_d  = 1'b1;
            end
            default: state_d = ST_STOPPED;
        endcase

        if (ZERO) begin
            pre_d = '0;
        end else if (enabled) begin
            pre_d = pre_tc ? '0 : pre_q + PW'(1);
        end

        square_d = square_q ^ tick_d;
    end

    always_ff @(negedge CLOCK or negedge CLEAR) begin
        if (!CLEAR) begin
            state_q   <= ST_STOPPED;
            pre_q     <= '0;
            act_sel_q <= '0;
            tick_q    <= 1'b0;
            square_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            act_sel_q <= act_sel_d;
            tick_q    <= tick_d;
            square_q  <= square_d;
        end
    end

    assign TICK    = tick_q;
    assign SQUARE  = square_q;
    assign RUNNING = (state_q == ST_RUN);
    assign ACT_SEL = act_sel_q;

endmodule
